// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter sharing one external shifter between two requesters
module shift_arbiter #(
  parameter int SH_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req_valid,
  output logic        a_req_ready,
  input  logic [31:0] a_data,
  input  logic [4:0]  a_shamt,
  input  logic        a_right,
  input  logic        a_arith,
  output logic        a_rsp_valid,
  input  logic        a_rsp_ready,
  output logic [31:0] a_rsp_data,
  input  logic        b_req_valid,
  output logic        b_req_ready,
  input  logic [31:0] b_data,
  input  logic [4:0]  b_shamt,
  input  logic        b_right,
  input  logic        b_arith,
  output logic        b_rsp_valid,
  input  logic        b_rsp_ready,
  output logic [31:0] b_rsp_data,
  output logic [31:0] sh_data,
  output logic [4:0]  sh_shamt,
  output logic        sh_right,
  output logic        sh_arith,
  input  logic [31:0] sh_result,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, RESP} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, id_q, id_d, right_q, right_d, arith_q, arith_d;
  logic [1:0] cnt_q, cnt_d;
  logic [4:0] shamt_q, shamt_d;
  logic [31:0] data_q, data_d, res_q, res_d;
  logic idle, gnt_b;
  assign idle = state_q == IDLE;
  // last_q=1 means B was granted last, so B only wins a tie after A
  assign gnt_b = b_req_valid && (!a_req_valid || !last_q);
  assign a_req_ready = idle;
  assign b_req_ready = idle;
  assign busy = !idle;
  assign a_rsp_valid = state_q == RESP && !id_q;
  assign b_rsp_valid = state_q == RESP && id_q;
  assign a_rsp_data = res_q;
  assign b_rsp_data = res_q;
  assign sh_data = data_q;
  assign sh_shamt = shamt_q;
  assign sh_right = right_q;
  assign sh_arith = arith_q;
  // next state: accept and latch in IDLE, wait out shifter latency, hold response until taken
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    cnt_d = cnt_q;
    data_d = data_q;
    shamt_d = shamt_q;
    right_d = right_q;
    arith_d = arith_q;
    res_d = res_q;
    case (state_q)
      IDLE: if (a_req_valid || b_req_valid) begin
        state_d = SHIFT;
        last_d = gnt_b;
        id_d = gnt_b;
        cnt_d = 2'(SH_LAT - 1);
        data_d = gnt_b ? b_data : a_data;
        shamt_d = gnt_b ? b_shamt : a_shamt;
        right_d = gnt_b ? b_right : a_right;
        arith_d = gnt_b ? b_right && b_arith : a_right && a_arith;
      end
      SHIFT: if (cnt_q == 2'd0) begin
        res_d = sh_result;
        state_d = RESP;
      end else cnt_d = cnt_q - 2'd1;
      RESP: if (id_q ? b_rsp_ready : a_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      id_q <= 1'b0;
      cnt_q <= '0;
      data_q <= '0;
      shamt_q <= '0;
      right_q <= 1'b0;
      arith_q <= 1'b0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      data_q <= data_d;
      shamt_q <= shamt_d;
      right_q <= right_d;
      arith_q <= arith_d;
      res_q <= res_d;
    end
  end
endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 Parameter SH_LAT, default 1, sets the shifter latency in cycles from operands driven to sh_result valid; legal range is 1..4.
REQ-002 Port clk, input, 1, is the only clock; every register SHALL update on its rising edge.
REQ-003 Port rst, input, 1, is a synchronous, active-high reset sampled on the rising edge of clk.
REQ-004 Ports a_req_valid (input, 1) and a_req_ready (output, 1) SHALL form requester A's request handshake.
REQ-005 Requester A's operand ports, all inputs: a_data (32) data word, a_shamt (5) shift amount, a_right (1, 1=right), a_arith (1, 1=arithmetic right).
REQ-006 Ports a_rsp_valid (output, 1), a_rsp_ready (input, 1) and a_rsp_data (output, 32) SHALL form requester A's response channel.
REQ-007 Requester B SHALL have the same set of ports with the prefix b_ in place of a_.
REQ-008 Shared-shifter outputs: sh_data (32), sh_shamt (5), sh_right (1), sh_arith (1).
REQ-009 Port sh_result, input, 32, SHALL carry the shifted word returned by the shared shifter.
REQ-010 Port busy, output, 1, SHALL be high whenever the FSM is not in IDLE.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and RESP.
REQ-012 In IDLE, a_req_ready = b_req_ready = 1; in every other state both ready outputs SHALL be 0.
REQ-013 A request is accepted on a cycle in IDLE where the requester's valid is 1 and it is granted.
REQ-014 When only one requester is valid, that requester SHALL be granted.
REQ-015 When both requesters are valid in the same IDLE cycle, the requester opposite last_grant SHALL be granted, i.e. round-robin.
REQ-016 last_grant SHALL update on every accept to the granted requester.
REQ-017 On accept, the granted requester's data, shamt, right and arith SHALL be latched into operand registers, its ID latched, and the FSM SHALL go to SHIFT.
REQ-018 The sh_* outputs SHALL always reflect the operand registers, so they stay stable for the whole of SHIFT.
REQ-019 On entry to SHIFT, a wait counter SHALL load SH_LAT-1 and decrement once per cycle.
REQ-020 On the SHIFT cycle where the wait counter is 0, sh_result SHALL be captured into the result register and the FSM SHALL go to RESP.
REQ-021 With SH_LAT=1 the latency is: accept at cycle N, capture at the end of N+1, rsp_valid high at N+2; in general rsp_valid rises SH_LAT+1 cycles after accept.
REQ-022 In RESP only the latched ID's x_rsp_valid SHALL be 1, and both x_rsp_data outputs SHALL equal the result register.
REQ-023 RESP SHALL hold the response unchanged until the matching x_rsp_ready is 1; the FSM SHALL then go to IDLE on that edge.
REQ-024 The rsp_ready of the non-granted requester SHALL be ignored.
REQ-025 Requests arriving in SHIFT or RESP SHALL see ready=0 and SHALL NOT be latched or lost; the requester holds valid until it is accepted.
REQ-026 A new request SHALL NOT be accepted in the same cycle a response completes; the earliest next accept is the following IDLE cycle, giving a minimum throughput of 1 op per SH_LAT+2 cycles.
REQ-027 A request with shamt=0 SHALL pass through the same sequence with no shortcut.
REQ-028 The response for shamt=0 SHALL be the unmodified data word.
REQ-029 When right=0, arith SHALL be forwarded to the shifter as 0.

Reset
REQ-030 While rst=1: the FSM SHALL go to IDLE and last_grant SHALL be set to B, so A wins the first tie.
REQ-031 While rst=1, the wait counter, operand, ID and result registers SHALL clear to 0.
REQ-032 While rst=1, all rsp_valid outputs and busy SHALL be 0, and all sh_* and rsp_data outputs SHALL be 0.
REQ-033 On the first cycle after reset, with no request pending, a_req_ready and b_req_ready SHALL be 1.
REQ-034 Reset asserted in SHIFT or RESP SHALL abort the operation; the pending response SHALL be discarded and never presented.

Verification
REQ-035 SH_LAT=1; A requests data=8FFFFFFF, shamt=4, right=1, arith=0 -> sh_* stable at N+1; a_rsp_valid at N+2 with data 08FFFFFF; b_rsp_valid stays 0.
REQ-036 Same operands with arith=1 -> a_rsp_data=F8FFFFFF.
REQ-037 Same data with right=0, shamt=31 -> a_rsp_data=80000000.
REQ-038 A and B valid together from reset -> grant order is A, then B, then A; each requester's response carries its own result; there are no back-to-back accepts.
REQ-039 a_rsp_ready held 0 for 5 cycles in RESP -> a_rsp_valid and a_rsp_data stay constant, and b_req_ready stays 0 throughout.
REQ-040 SH_LAT=3, shamt=0 -> response equals the input word exactly 4 cycles after accept.
REQ-041 rst pulsed during SHIFT -> no rsp_valid is ever seen for that operation, busy=0 on the next cycle, and both req_ready outputs are 1.
